// File: rtl/lab1_pkg.sv
// Shared definitions for the lab1 PIO interrupt sequencer: PIO register map,
// sequencer state encoding and the state-to-bus-control decode.
package lab1_pkg;

  // PIO register offsets (word addresses on the Avalon-MM slave)
  localparam logic [1:0] PIO_DATA    = 2'd0;
  localparam logic [1:0] PIO_IRQMASK = 2'd2;
  localparam logic [1:0] PIO_EDGECAP = 2'd3;

  typedef enum logic [3:0] {
    INIT     = 4'd0,
    IDLE     = 4'd1,
    WR_MASK  = 4'd2,
    RD_CAP   = 4'd3,
    CAP_LAT  = 4'd4,
    CLR      = 4'd5,
    RD_DATA  = 4'd6,
    DATA_LAT = 4'd7,
    HOLD     = 4'd8
  } state_t;

  typedef struct packed {
    logic       chipselect;
    logic       write_n;
    logic [1:0] address;
  } bus_ctl_t;

  // Bus control for each state; every access is a single cycle, so the
  // strobes are a pure function of the current state.
  function automatic bus_ctl_t bus_decode(input state_t state);
    bus_ctl_t ctl;
    ctl = '{chipselect: 1'b0, write_n: 1'b1, address: PIO_DATA};
    case (state)
      INIT, WR_MASK: ctl = '{chipselect: 1'b1, write_n: 1'b0, address: PIO_IRQMASK};
      RD_CAP:        ctl = '{chipselect: 1'b1, write_n: 1'b1, address: PIO_EDGECAP};
      CLR:           ctl = '{chipselect: 1'b1, write_n: 1'b0, address: PIO_EDGECAP};
      RD_DATA:       ctl = '{chipselect: 1'b1, write_n: 1'b1, address: PIO_DATA};
      default:       ;
    endcase
    return ctl;
  endfunction

endpackage

// File: rtl/lab1_pio_irq_sequencer.sv
// Avalon-MM master that services an edge-capture PIO in hardware: programs
// irq_mask, and on each interrupt reads edge_capture, clears it, samples the
// data register and pushes one {capture, data} event onto a valid/ready port.
module lab1_pio_irq_sequencer
  import lab1_pkg::*;
#(
  parameter int unsigned       DATA_W         = 8,
  parameter logic [DATA_W-1:0] MASK_RESET     = DATA_W'(8'hFF),
  parameter int unsigned       HOLDOFF_CYCLES = 0,
  parameter int unsigned       CNT_W          = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  // Avalon-MM master towards the PIO
  output logic [1:0]        pio_address,
  output logic              pio_chipselect,
  output logic              pio_write_n,
  output logic [31:0]       pio_writedata,
  input  logic [31:0]       pio_readdata,
  input  logic              pio_irq,
  // Mask reprogramming request
  input  logic [DATA_W-1:0] cfg_mask,
  input  logic              cfg_load,
  // Event stream
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [DATA_W-1:0] evt_capture,
  output logic [DATA_W-1:0] evt_data,
  output logic [CNT_W-1:0]  evt_count,
  output logic              busy
);

  // Hold-off counter loads HOLDOFF_CYCLES-1 and counts down to zero, so the
  // FSM spends exactly HOLDOFF_CYCLES cycles in HOLD.
  localparam int unsigned       HOLD_W    = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'((HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 32'd0);
  localparam state_t            AFTER_SVC = (HOLDOFF_CYCLES == 0) ? IDLE : HOLD;

  state_t            r_state;
  logic [DATA_W-1:0] r_cap_q;
  logic              r_cfg_pend;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic              r_evt_valid;
  logic [DATA_W-1:0] r_evt_capture;
  logic [DATA_W-1:0] r_evt_data;
  logic [CNT_W-1:0]  r_evt_count;

  bus_ctl_t          w_bus;
  logic [31:0]       w_wdata;
  logic [DATA_W-1:0] w_rd;

  assign w_rd = pio_readdata[DATA_W-1:0];

  // Only the low DATA_W bits of the PIO read data carry information.
  if (DATA_W < 32) begin : g_rd_hi
    logic w_unused_rd_hi;
    assign w_unused_rd_hi = ^pio_readdata[31:DATA_W];
  end

  // Bus strobes and write data decoded from the state register; the bus is
  // forced idle while reset is held so INIT does not write during reset.
  always_comb begin
    // NOTE: defaults first so every path assigns every output -- no latches.
    w_bus   = bus_decode(r_state);
    w_wdata = '0;
    case (r_state)
      INIT:    w_wdata = 32'(MASK_RESET);
      WR_MASK: w_wdata = 32'(cfg_mask);
      default: ;
    endcase
    if (!reset_n) begin
      w_bus   = '{chipselect: 1'b0, write_n: 1'b1, address: PIO_DATA};
      w_wdata = '0;
    end
  end

  assign pio_chipselect = w_bus.chipselect;
  assign pio_write_n    = w_bus.write_n;
  assign pio_address    = w_bus.address;
  assign pio_writedata  = w_wdata;

  assign evt_valid   = r_evt_valid;
  assign evt_capture = r_evt_capture;
  assign evt_data    = r_evt_data;
  assign evt_count   = r_evt_count;
  assign busy        = (r_state != IDLE);

  // Sequencer FSM with the mask request flag, hold-off counter and event register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= INIT;
      r_cap_q       <= '0;
      r_cfg_pend    <= 1'b0;
      r_hold_cnt    <= '0;
      r_evt_valid   <= 1'b0;
      r_evt_capture <= '0;
      r_evt_data    <= '0;
      r_evt_count   <= '0;
    end else begin
      // NOTE: non-blocking throughout; a later assignment in this block
      // overrides an earlier one, which gives the load-beats-accept priority.
      if (cfg_load) r_cfg_pend <= 1'b1;
      if (r_evt_valid && evt_ready) r_evt_valid <= 1'b0;

      case (r_state)
        INIT: r_state <= IDLE;

        IDLE: begin
          if (r_cfg_pend) begin
            r_state <= WR_MASK;
          end else if (pio_irq && (!r_evt_valid || evt_ready)) begin
            r_state <= RD_CAP;
          end
        end

        WR_MASK: begin
          // A request arriving during the write stays pending for one more write.
          r_cfg_pend <= cfg_load;
          r_state    <= IDLE;
        end

        RD_CAP: r_state <= CAP_LAT;

        CAP_LAT: begin
          r_cap_q <= w_rd;
          if (w_rd == '0) begin
            // Spurious interrupt: nothing captured, so no clear and no event.
            r_state    <= AFTER_SVC;
            r_hold_cnt <= HOLD_LOAD;
          end else begin
            r_state <= CLR;
          end
        end

        CLR: r_state <= RD_DATA;

        RD_DATA: r_state <= DATA_LAT;

        DATA_LAT: begin
          r_evt_data    <= w_rd;
          r_evt_capture <= r_cap_q;
          r_evt_valid   <= 1'b1;
          r_evt_count   <= r_evt_count + CNT_W'(1);
          r_state       <= AFTER_SVC;
          r_hold_cnt    <= HOLD_LOAD;
        end

        HOLD: begin
          if (r_hold_cnt == '0) r_state <= IDLE;
          else                  r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
        end

        default: r_state <= INIT;
      endcase
    end
  end

endmodule
